// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types, default-format constants and operand classification for fp_addsub_seq
package fp_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int BIAS     = (1 << (FP_EXP_W - 1)) - 1;
   localparam int EXP_MAX  = 2 * BIAS + 1;
   localparam int SIG_W    = FP_MAN_W + 1;
   localparam int WORK_W   = FP_MAN_W + 4;

   typedef enum logic [2:0] {
      IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE
   } state_e;

   typedef enum logic [1:0] {
      FP_ZERO, FP_NORMAL, FP_INF, FP_NAN
   } fp_class_e;

   // Subnormals (exp=0, frac!=0) classify as zero: they are flushed on input.
   function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                          input logic frac_zero);
      if (exp_zero)
         return FP_ZERO;
      else if (!exp_ones)
         return FP_NORMAL;
      else if (frac_zero)
         return FP_INF;
      else
         return FP_NAN;
   endfunction

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even of a {sig,G,R,S} working significand
module fp_round_rne #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [MAN_W+3:0] sig,
   input  logic [EXP_W:0]   exp_in,
   output logic [MAN_W-1:0] frac,
   output logic [EXP_W-1:0] exp_out,
   output logic             overflow,
   output logic             inexact
);

   logic             inc;
   logic [MAN_W+1:0] rounded;
   logic [EXP_W:0]   exp_full;

   assign inc     = sig[2] & (sig[1] | sig[0] | sig[3]);
   assign rounded = {1'b0, sig[MAN_W+3:3]} + (MAN_W+2)'(inc);

   // A carry out of the increment leaves 10...0, so the fraction is zero and exp bumps.
   always_comb begin
      if (rounded[MAN_W+1]) begin
         frac     = rounded[MAN_W:1];
         exp_full = exp_in + (EXP_W+1)'(1);
      end else begin
         frac     = rounded[MAN_W-1:0];
         exp_full = exp_in;
      end
   end

   assign exp_out  = exp_full[EXP_W-1:0];
   assign overflow = exp_full >= {1'b0, {EXP_W{1'b1}}};
   assign inexact  = (|sig[2:0]) | overflow;

endmodule

// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - multi-cycle parametrised floating-point adder/subtractor with valid/ready
module fp_addsub_seq
   import fp_pkg::*;
#(
   parameter int EXP_W = $clog2(EXP_MAX + 1),
   parameter int MAN_W = SIG_W - 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 op_sub,
   input  logic [EXP_W+MAN_W:0] in_a,
   input  logic [EXP_W+MAN_W:0] in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 flag_invalid,
   output logic                 flag_overflow,
   output logic                 flag_underflow,
   output logic                 flag_inexact
);

   localparam int FP_W      = 1 + EXP_W + MAN_W;
   localparam int GRS_W     = WORK_W - SIG_W;
   localparam int WORK_BITS = MAN_W + 1 + GRS_W;
   localparam int MAX_SHIFT = MAN_W + 3;
   localparam int CNT_W     = $clog2(MAN_W + 4);
   localparam logic [FP_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   state_e                      state, next_state;
   logic [FP_W-1:0]             a_q, b_q;
   logic [EXP_W:0]              exp_r;
   logic [WORK_BITS-1:0]        sig_big, sig_small;
   logic [WORK_BITS:0]          sum_r;
   logic [CNT_W-1:0]            shift_cnt;
   logic                        sign_r, eff_sub;

   logic                        a_s, b_s;
   logic [EXP_W-1:0]            a_e, b_e;
   logic [MAN_W-1:0]            a_f, b_f;
   fp_class_e                   cls_a, cls_b;
   logic                        is_special, spec_invalid;
   logic [FP_W-1:0]             spec_result;
   logic [EXP_W+MAN_W-1:0]      mag_a, mag_b, big_mag, small_mag;
   logic                        swap;
   logic [EXP_W-1:0]            big_e, small_e;
   logic [EXP_W:0]              d_exp, exp_dec;
   logic [CNT_W-1:0]            align_cnt;
   logic [WORK_BITS:0]          add_sum;
   logic [WORK_BITS-1:0]        norm_shl;
   logic                        norm_uf;
   logic [MAN_W-1:0]            rnd_frac;
   logic [EXP_W-1:0]            rnd_exp;
   logic                        rnd_ovf, rnd_inexact;

   assign {a_s, a_e, a_f} = a_q;
   assign {b_s, b_e, b_f} = b_q;
   assign cls_a = classify(a_e == '0, a_e == '1, a_f == '0);
   assign cls_b = classify(b_e == '0, b_e == '1, b_f == '0);

   always_comb begin
      is_special   = 1'b1;
      spec_invalid = 1'b0;
      spec_result  = QNAN;
      if (cls_a == FP_NAN || cls_b == FP_NAN)
         spec_result = QNAN;
      else if (cls_a == FP_INF && cls_b == FP_INF) begin
         if (a_s != b_s)
            spec_invalid = 1'b1;
         else
            spec_result = a_q;
      end else if (cls_a == FP_INF)
         spec_result = a_q;
      else if (cls_b == FP_INF)
         spec_result = b_q;
      else if (cls_a == FP_ZERO && cls_b == FP_ZERO)
         spec_result = {a_s & b_s, {(FP_W-1){1'b0}}};
      else
         is_special = 1'b0;
   end

   // Zero-class magnitudes are masked so flushed subnormals get no hidden bit and exp 0.
   assign mag_a     = (cls_a == FP_ZERO) ? '0 : {a_e, a_f};
   assign mag_b     = (cls_b == FP_ZERO) ? '0 : {b_e, b_f};
   assign swap      = mag_b > mag_a;
   assign big_mag   = swap ? mag_b : mag_a;
   assign small_mag = swap ? mag_a : mag_b;
   assign big_e     = big_mag[EXP_W+MAN_W-1 -: EXP_W];
   assign small_e   = small_mag[EXP_W+MAN_W-1 -: EXP_W];
   assign d_exp     = {1'b0, big_e} - {1'b0, small_e};

   always_comb begin
      if (int'(d_exp) > MAX_SHIFT)
         align_cnt = CNT_W'(MAX_SHIFT);
      else
         align_cnt = CNT_W'(d_exp);
   end

   assign add_sum  = eff_sub ? ({1'b0, sig_big} - {1'b0, sig_small})
                             : ({1'b0, sig_big} + {1'b0, sig_small});
   assign exp_dec  = exp_r - (EXP_W+1)'(1);
   assign norm_shl = {sum_r[WORK_BITS-2:0], 1'b0};
   assign norm_uf  = !sum_r[WORK_BITS] && (exp_dec == '0);

   fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
      .sig      (sum_r[WORK_BITS-1:0]),
      .exp_in   (exp_r),
      .frac     (rnd_frac),
      .exp_out  (rnd_exp),
      .overflow (rnd_ovf),
      .inexact  (rnd_inexact)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               next_state = UNPACK;
         end
         UNPACK: begin
            if (is_special)
               next_state = DONE;
            else if (align_cnt == '0)
               next_state = ADD;
            else
               next_state = ALIGN;
         end
         ALIGN:
            if (shift_cnt == CNT_W'(1))
               next_state = ADD;
         ADD: begin
            if (add_sum == '0)
               next_state = DONE;
            else if (add_sum[WORK_BITS] || !add_sum[WORK_BITS-1])
               next_state = NORM;
            else
               next_state = ROUND;
         end
         NORM: begin
            if (sum_r[WORK_BITS])
               next_state = ROUND;
            else if (norm_uf)
               next_state = DONE;
            else if (norm_shl[WORK_BITS-1])
               next_state = ROUND;
         end
         ROUND:
            next_state = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               next_state = IDLE;
         end
         default:
            next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q            <= '0;
         b_q            <= '0;
         exp_r          <= '0;
         sig_big        <= '0;
         sig_small      <= '0;
         sum_r          <= '0;
         shift_cnt      <= '0;
         sign_r         <= 1'b0;
         eff_sub        <= 1'b0;
         result         <= '0;
         flag_invalid   <= 1'b0;
         flag_overflow  <= 1'b0;
         flag_underflow <= 1'b0;
         flag_inexact   <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (in_valid) begin
                  a_q <= in_a;
                  b_q <= {in_b[FP_W-1] ^ op_sub, in_b[FP_W-2:0]};
               end
            UNPACK:
               if (is_special) begin
                  result         <= spec_result;
                  flag_invalid   <= spec_invalid;
                  flag_overflow  <= 1'b0;
                  flag_underflow <= 1'b0;
                  flag_inexact   <= 1'b0;
               end else begin
                  sig_big   <= {1'b1, big_mag[MAN_W-1:0], {GRS_W{1'b0}}};
                  sig_small <= {small_e != '0, small_mag[MAN_W-1:0], {GRS_W{1'b0}}};
                  exp_r     <= {1'b0, big_e};
                  sign_r    <= swap ? b_s : a_s;
                  eff_sub   <= a_s ^ b_s;
                  shift_cnt <= align_cnt;
               end
            ALIGN: begin
               sig_small <= {1'b0, sig_small[WORK_BITS-1:2], sig_small[1] | sig_small[0]};
               shift_cnt <= shift_cnt - CNT_W'(1);
            end
            ADD: begin
               sum_r <= add_sum;
               if (add_sum == '0) begin
                  result         <= '0;
                  flag_invalid   <= 1'b0;
                  flag_overflow  <= 1'b0;
                  flag_underflow <= 1'b0;
                  flag_inexact   <= 1'b0;
               end
            end
            NORM:
               if (sum_r[WORK_BITS]) begin
                  sum_r <= {1'b0, sum_r[WORK_BITS:2], sum_r[1] | sum_r[0]};
                  exp_r <= exp_r + (EXP_W+1)'(1);
               end else begin
                  sum_r <= {1'b0, norm_shl};
                  exp_r <= exp_dec;
                  if (norm_uf) begin
                     result         <= {sign_r, {(FP_W-1){1'b0}}};
                     flag_invalid   <= 1'b0;
                     flag_overflow  <= 1'b0;
                     flag_underflow <= 1'b1;
                     flag_inexact   <= 1'b1;
                  end
               end
            ROUND: begin
               if (rnd_ovf)
                  result <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               else
                  result <= {sign_r, rnd_exp, rnd_frac};
               flag_invalid   <= 1'b0;
               flag_overflow  <= rnd_ovf;
               flag_underflow <= 1'b0;
               flag_inexact   <= rnd_inexact;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb/tb_fp_addsub_seq.sv - directed self-checking bench for fp_addsub_seq in single precision
module tb_fp_addsub_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        op_sub;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        flag_invalid;
   logic        flag_overflow;
   logic        flag_underflow;
   logic        flag_inexact;
   logic [3:0]  flags_obs;

   int n_cmp = 0;
   int n_bad = 0;

   assign flags_obs = {flag_invalid, flag_overflow, flag_underflow, flag_inexact};

   fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .op_sub         (op_sub),
      .in_a           (in_a),
      .in_b           (in_b),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .result         (result),
      .flag_invalid   (flag_invalid),
      .flag_overflow  (flag_overflow),
      .flag_underflow (flag_underflow),
      .flag_inexact   (flag_inexact)
   );

   always #5 clk = ~clk;

   // Latency counts the accept edge as 1 and includes the edge that raises out_valid.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output int lat);
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      op_sub   = sub;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      op_sub    = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_handshake in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
      n_cmp++;
      if (result !== 32'h0 || flags_obs !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_outputs result=%h flags=%b want 00000000/0000", result, flags_obs);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_add_basic();
      int lat;
      do_op(32'h3F800000, 32'h3F800000, 1'b0, lat);
      n_cmp++;
      if (result !== 32'h40000000) begin
         n_bad++;
         $display("FAIL add_1p1 result got %h want 40000000", result);
      end
      n_cmp++;
      if (flags_obs !== 4'b0000) begin
         n_bad++;
         $display("FAIL add_1p1_flags got %b want 0000", flags_obs);
      end
      n_cmp++;
      if (lat !== 5) begin
         n_bad++;
         $display("FAIL add_1p1_latency got %0d want 5", lat);
      end
      take_result();
   endtask

   task automatic test_sub_align_norm();
      int lat;
      do_op(32'h3FC00000, 32'h3F400000, 1'b1, lat);
      n_cmp++;
      if (result !== 32'h3F400000 || flags_obs !== 4'b0000) begin
         n_bad++;
         $display("FAIL sub_align result=%h flags=%b want 3f400000/0000", result, flags_obs);
      end
      n_cmp++;
      if (lat !== 6) begin
         n_bad++;
         $display("FAIL sub_align_latency got %0d want 6", lat);
      end
      take_result();
   endtask

   task automatic test_round_even();
      int lat;
      do_op(32'h3F800000, 32'h33800000, 1'b0, lat);
      n_cmp++;
      if (result !== 32'h3F800000 || flags_obs !== 4'b0001) begin
         n_bad++;
         $display("FAIL round_tie result=%h flags=%b want 3f800000/0001", result, flags_obs);
      end
      n_cmp++;
      if (lat !== 28) begin
         n_bad++;
         $display("FAIL round_tie_latency got %0d want 28", lat);
      end
      take_result();
      do_op(32'h3F800000, 32'h33800001, 1'b0, lat);
      n_cmp++;
      if (result !== 32'h3F800001 || flags_obs !== 4'b0001) begin
         n_bad++;
         $display("FAIL round_up result=%h flags=%b want 3f800001/0001", result, flags_obs);
      end
      take_result();
   endtask

   task automatic test_overflow_invalid();
      int lat;
      do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, lat);
      n_cmp++;
      if (result !== 32'h7F800000 || flags_obs !== 4'b0101) begin
         n_bad++;
         $display("FAIL overflow result=%h flags=%b want 7f800000/0101", result, flags_obs);
      end
      take_result();
      do_op(32'h7F800000, 32'h7F800000, 1'b1, lat);
      n_cmp++;
      if (result !== 32'h7FC00000 || flags_obs !== 4'b1000) begin
         n_bad++;
         $display("FAIL inf_minus_inf result=%h flags=%b want 7fc00000/1000", result, flags_obs);
      end
      n_cmp++;
      if (lat !== 2) begin
         n_bad++;
         $display("FAIL special_latency got %0d want 2", lat);
      end
      take_result();
   endtask

   task automatic test_zero_hold();
      int lat;
      do_op(32'h40490FDB, 32'h40490FDB, 1'b1, lat);
      n_cmp++;
      if (result !== 32'h00000000 || flags_obs !== 4'b0000) begin
         n_bad++;
         $display("FAIL zero_diff result=%h flags=%b want 00000000/0000", result, flags_obs);
      end
      n_cmp++;
      if (lat !== 3) begin
         n_bad++;
         $display("FAIL zero_diff_latency got %0d want 3", lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if (result !== 32'h0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_cycle%0d result=%h out_valid=%b in_ready=%b want 0/1/0",
                     i, result, out_valid, in_ready);
         end
      end
      take_result();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL back_to_idle in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_async_reset();
      int lat;
      @(negedge clk);
      in_a     = 32'h3F800000;
      in_b     = 32'h33800001;
      op_sub   = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
         n_bad++;
         $display("FAIL async_reset out_valid=%b in_ready=%b result=%h want 0/1/00000000",
                  out_valid, in_ready, result);
      end
      @(negedge clk);
      reset = 1'b0;
      do_op(32'h3F800000, 32'h3F800000, 1'b0, lat);
      n_cmp++;
      if (result !== 32'h40000000 || flags_obs !== 4'b0000 || lat !== 5) begin
         n_bad++;
         $display("FAIL after_reset result=%h flags=%b lat=%0d want 40000000/0000/5",
                  result, flags_obs, lat);
      end
      take_result();
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_sub_align_norm();
      test_round_even();
      test_overflow_invalid();
      test_zero_hold();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
